mod_n_updown_prog_counter: RTL and testbench

- Next-generation mod-N up/down counter.
- Adds the following over the fixed-modulus counter:
  - width N is parametrised;
  - the modulus is programmable at runtime;
  - step size is programmable;
  - synchronous parallel load;
  - count enable;
  - wrap or saturate mode;
  - a registered terminal-count/wrap indication for cascading.
- Sits in the counters library as the general-purpose replacement for the fixed mod-n counters (timers, dividers, address generators).

---
 rtl/counter_pkg.sv | 17 +
 rtl/mod_step_calc.sv | 66 ++++++
 rtl/mod_n_updown_prog_counter.sv | 128 ++++++++++++
 tb/tb_mod_n_updown_prog_counter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counters library: count-mode encodings and
// the legal-modulus range helper used when a new modulus is written.
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   function automatic int mod_limit(input int width);
      return 1 << width;
   endfunction

   // A modulus is usable when it gives at least two states and fits the counter.
   function automatic logic mod_in_range(input int val, input int width);
      return (val >= 2) && (val <= mod_limit(width));
   endfunction

endpackage

// File: rtl/mod_step_calc.sv
// Combinational next-count for one enabled step: wrap or saturate arithmetic
// at N+1 bits so a full 2^N modulus never overflows the intermediate.
module mod_step_calc
   import counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] out,
   input  logic [N-1:0] step,
   input  logic [N:0]   mod,
   input  logic         up_down,
   input  logic         sat_mode,
   output logic [N-1:0] nxt_val,
   output logic         wrap_flag,
   output logic         clamp_flag
);

   localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

   logic [N:0] out_w;
   logic [N:0] step_w;
   logic [N:0] sum_w;
   logic [N:0] lim_w;
   logic       step_nz;

   assign out_w   = {1'b0, out};
   assign step_w  = {1'b0, step};
   assign sum_w   = out_w + step_w;
   assign lim_w   = mod - ONE;
   assign step_nz = (step != '0);

   always_comb begin
      nxt_val    = out;
      wrap_flag  = 1'b0;
      clamp_flag = 1'b0;
      if (up_down) begin
         if (sum_w >= mod) begin
            if (sat_mode == MODE_WRAP) begin
               nxt_val   = N'(sum_w - mod);
               wrap_flag = 1'b1;
            end else begin
               // Already parked on the top limit: no new terminal event.
               nxt_val    = N'(lim_w);
               clamp_flag = 1'b1;
               wrap_flag  = (out_w != lim_w);
            end
         end else begin
            nxt_val   = N'(sum_w);
            wrap_flag = (sat_mode == MODE_SAT) && step_nz && (sum_w == lim_w);
         end
      end else begin
         if (out_w >= step_w) begin
            nxt_val   = out - step;
            wrap_flag = (sat_mode == MODE_SAT) && step_nz && (out == step);
         end else if (sat_mode == MODE_SAT) begin
            nxt_val    = '0;
            clamp_flag = 1'b1;
            wrap_flag  = (out != '0);
         end else begin
            nxt_val   = N'(out_w + mod - step_w);
            wrap_flag = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mod_n_updown_prog_counter.sv
// General-purpose mod-N up/down counter: runtime modulus, programmable step,
// parallel load, wrap/saturate modes and registered tc/sat/err flags.
module mod_n_updown_prog_counter
   import counter_pkg::*;
#(
   parameter int N       = 4,
   parameter int MOD_RST = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up_down,
   input  logic [N-1:0] step,
   input  logic         sat_mode,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         mod_wr,
   input  logic [N:0]   mod_val,
   output logic [N-1:0] out,
   output logic [N:0]   mod_q,
   output logic         tc,
   output logic         sat,
   output logic         err
);

   logic [N-1:0] cnt_p0;
   logic [N:0]   mod_p0;
   logic         tc_p0;
   logic         sat_p0;
   logic         err_p0;

   logic [N-1:0] cnt_d;
   logic [N:0]   mod_d;
   logic         tc_d;
   logic         sat_d;
   logic         err_d;

   logic         mod_acc;
   logic [N:0]   mod_eff;
   logic         load_ok;
   logic         force_clr;
   logic         count_go;
   logic         step_ok;
   logic [N-1:0] step_nxt;
   logic         step_wrap;
   logic         step_clamp;

   // A write that is accepted becomes the modulus for everything else on this edge.
   assign mod_acc   = mod_wr && mod_in_range(32'(mod_val), N);
   assign mod_eff   = mod_acc ? mod_val : mod_p0;
   assign load_ok   = load && ({1'b0, load_val} < mod_eff);
   assign force_clr = mod_acc && !load_ok && ({1'b0, cnt_p0} >= mod_val);
   assign count_go  = en && !load && !force_clr;
   assign step_ok   = ({1'b0, step} < mod_eff);

   mod_step_calc #(
      .N(N)
   ) u_step_calc (
      .out        (cnt_p0),
      .step       (step),
      .mod        (mod_eff),
      .up_down    (up_down),
      .sat_mode   (sat_mode),
      .nxt_val    (step_nxt),
      .wrap_flag  (step_wrap),
      .clamp_flag (step_clamp)
   );

   always_comb begin
      cnt_d = cnt_p0;
      mod_d = mod_p0;
      tc_d  = 1'b0;
      sat_d = sat_p0;
      err_d = 1'b0;
      if (mod_wr) begin
         if (mod_acc) begin
            mod_d = mod_val;
            sat_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
      if (load) begin
         if (load_ok) begin
            cnt_d = load_val;
            sat_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
      if (force_clr) begin
         cnt_d = '0;
      end
      if (count_go) begin
         if (step_ok) begin
            cnt_d = step_nxt;
            tc_d  = step_wrap;
            sat_d = step_clamp;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Stage p0: the only register stage; every output comes straight from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0 <= '0;
         mod_p0 <= (N+1)'(MOD_RST);
         tc_p0  <= 1'b0;
         sat_p0 <= 1'b0;
         err_p0 <= 1'b0;
      end else begin
         cnt_p0 <= cnt_d;
         mod_p0 <= mod_d;
         tc_p0  <= tc_d;
         sat_p0 <= sat_d;
         err_p0 <= err_d;
      end
   end

   assign out   = cnt_p0;
   assign mod_q = mod_p0;
   assign tc    = tc_p0;
   assign sat   = sat_p0;
   assign err   = err_p0;

endmodule

// File: tb/tb_mod_n_updown_prog_counter.sv
// Bench for mod_n_updown_prog_counter: directed vector table followed by
// randomized traffic against an integer-arithmetic reference model.
module tb_mod_n_updown_prog_counter;

   localparam int N       = 4;
   localparam int MOD_RST = 10;

   typedef struct {
      logic       rst;
      logic       en;
      logic       ud;
      logic [3:0] step;
      logic       satm;
      logic       load;
      logic [3:0] lv;
      logic       mw;
      logic [4:0] mv;
      int         e_out;
      int         e_mod;
      logic       e_tc;
      logic       e_sat;
      logic       e_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up_down;
   logic [3:0] step;
   logic       sat_mode;
   logic       load;
   logic [3:0] load_val;
   logic       mod_wr;
   logic [4:0] mod_val;
   logic [3:0] cnt_out;
   logic [4:0] mod_q;
   logic       tc;
   logic       sat;
   logic       err;

   int checks   = 0;
   int failures = 0;
   vec_t vecs[$];

   int m_out;
   int m_mod;
   int m_tc;
   int m_sat;
   int m_err;

   always #5 clk = ~clk;

   mod_n_updown_prog_counter #(
      .N(N),
      .MOD_RST(MOD_RST)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_down  (up_down),
      .step     (step),
      .sat_mode (sat_mode),
      .load     (load),
      .load_val (load_val),
      .mod_wr   (mod_wr),
      .mod_val  (mod_val),
      .out      (cnt_out),
      .mod_q    (mod_q),
      .tc       (tc),
      .sat      (sat),
      .err      (err)
   );

   function automatic void add(input logic r, input logic e, input logic u, input int st,
                               input logic sm, input logic ld, input int lv, input logic mw,
                               input int mv, input int eo, input int em, input logic et,
                               input logic es, input logic ee);
      vec_t v;
      v.rst = r; v.en = e; v.ud = u; v.step = 4'(st); v.satm = sm;
      v.load = ld; v.lv = 4'(lv); v.mw = mw; v.mv = 5'(mv);
      v.e_out = eo; v.e_mod = em; v.e_tc = et; v.e_sat = es; v.e_err = ee;
      vecs.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; en = v.en; up_down = v.ud; step = v.step; sat_mode = v.satm;
      load = v.load; load_val = v.lv; mod_wr = v.mw; mod_val = v.mv;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Reference: one edge worked out from the counting rules with signed integers.
   function automatic void model_edge(input vec_t v);
      int meff;
      int tgt;
      int lim;
      bit mw_ok;
      bit loaded;
      bit cleared;
      if (v.rst) begin
         m_out = 0; m_mod = MOD_RST; m_tc = 0; m_sat = 0; m_err = 0;
         return;
      end
      m_tc = 0; m_err = 0; meff = m_mod; loaded = 0; cleared = 0;
      mw_ok = v.mw && (int'(v.mv) >= 2) && (int'(v.mv) <= (1 << N));
      if (v.mw) begin
         if (mw_ok) begin
            meff = int'(v.mv); m_mod = meff; m_sat = 0;
         end else m_err = 1;
      end
      if (v.load) begin
         if (int'(v.lv) < meff) begin
            m_out = int'(v.lv); loaded = 1; m_sat = 0;
         end else m_err = 1;
      end
      if (mw_ok && !loaded && m_out >= meff) begin
         m_out = 0; cleared = 1;
      end
      if (v.en && !v.load && !cleared) begin
         if (int'(v.step) >= meff) m_err = 1;
         else if (v.step == 4'd0) m_sat = 0;
         else begin
            tgt = v.ud ? m_out + int'(v.step) : m_out - int'(v.step);
            if (!v.satm) begin
               m_sat = 0;
               if (tgt >= meff) begin
                  m_out = tgt - meff; m_tc = 1;
               end else if (tgt < 0) begin
                  m_out = tgt + meff; m_tc = 1;
               end else m_out = tgt;
            end else begin
               lim = v.ud ? meff - 1 : 0;
               if ((v.ud && tgt > lim) || (!v.ud && tgt < lim)) begin
                  m_tc = (m_out != lim) ? 1 : 0; m_out = lim; m_sat = 1;
               end else begin
                  m_tc = (tgt == lim) ? 1 : 0; m_out = tgt; m_sat = 0;
               end
            end
         end
      end
   endfunction

   initial begin
      vec_t r;
      logic satm_r;
      rst = 1'b1; en = 1'b0; up_down = 1'b1; step = '0; sat_mode = 1'b0;
      load = 1'b0; load_val = '0; mod_wr = 1'b0; mod_val = '0;

      // rst, en, ud, step, satm, load, lv, mw, mv | out, mod, tc, sat, err
      for (int i = 0; i < 3; i++) add(1,1,1,1,0,1,5,1,4, 0,10,0,0,0);
      for (int i = 1; i <= 11; i++) add(0,1,1,1,0,0,0,0,0, i % 10,10, (i == 10),0,0);
      add(0,1,1,3,0,1,8,0,0,  8,10,0,0,0);
      add(0,1,1,3,0,0,0,0,0,  1,10,1,0,0);
      add(0,1,1,3,0,0,0,0,0,  4,10,0,0,0);
      add(0,1,1,3,0,0,0,0,0,  7,10,0,0,0);
      add(0,1,1,3,0,0,0,0,0,  0,10,1,0,0);
      add(0,0,0,4,0,1,2,0,0,  2,10,0,0,0);
      add(0,1,0,4,0,0,0,0,0,  8,10,1,0,0);
      add(0,0,0,4,1,1,2,0,0,  2,10,0,0,0);
      add(0,1,0,4,1,0,0,0,0,  0,10,1,1,0);
      add(0,1,0,4,1,0,0,0,0,  0,10,0,1,0);
      add(0,1,1,4,1,0,0,0,0,  4,10,0,0,0);
      add(0,1,1,5,1,0,0,0,0,  9,10,1,0,0);
      add(0,1,1,1,1,0,0,0,0,  9,10,0,1,0);
      add(0,0,1,1,0,1,7,0,0,  7,10,0,0,0);
      add(0,0,1,1,0,0,0,1,5,  0,5,0,0,0);
      add(0,0,1,1,0,0,0,1,1,  0,5,0,0,1);
      add(0,0,1,1,0,0,0,0,0,  0,5,0,0,0);
      add(0,0,1,1,0,0,0,1,17, 0,5,0,0,1);
      add(0,0,1,1,0,0,0,0,0,  0,5,0,0,0);
      add(0,0,1,1,0,1,6,0,0,  0,5,0,0,1);
      add(0,0,1,1,0,0,0,0,0,  0,5,0,0,0);
      add(0,0,1,1,0,1,12,1,16, 12,16,0,0,0);
      add(0,1,1,5,0,0,0,0,0,  1,16,1,0,0);
      add(0,1,1,1,0,0,0,0,0,  2,16,0,0,0);
      add(0,1,1,1,0,0,0,0,0,  3,16,0,0,0);
      add(1,1,1,1,0,0,0,0,0,  0,10,0,0,0);
      add(0,1,1,1,0,0,0,0,0,  1,10,0,0,0);
      add(0,1,1,1,0,0,0,0,0,  2,10,0,0,0);
      for (int i = 0; i < 5; i++) add(0,0,1,1,0,0,0,0,0, 2,10,0,0,0);
      add(0,0,1,1,0,1,5,0,0,  5,10,0,0,0);
      add(0,1,1,0,0,0,0,0,0,  5,10,0,0,0);
      add(0,1,1,12,0,0,0,0,0, 5,10,0,0,1);
      add(0,0,1,1,0,0,0,1,16, 5,16,0,0,0);
      add(0,1,0,6,0,0,0,0,0,  15,16,1,0,0);
      add(0,1,1,1,0,0,0,0,0,  0,16,1,0,0);
      add(0,0,1,1,1,1,15,0,0, 15,16,0,0,0);
      add(0,1,1,1,1,0,0,0,0,  15,16,0,1,0);
      add(0,0,1,1,1,0,0,1,12, 0,12,0,0,0);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out", i), int'(cnt_out), vecs[i].e_out);
         chk($sformatf("vec%0d_mod", i), int'(mod_q), vecs[i].e_mod);
         chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].e_tc));
         chk($sformatf("vec%0d_sat", i), int'(sat), int'(vecs[i].e_sat));
         chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].e_err));
      end

      satm_r = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 15) == 0) satm_r = ~satm_r;
         r.rst  = (c == 0) || ($urandom_range(0, 59) == 0);
         r.en   = ($urandom_range(0, 4) != 0);
         r.ud   = 1'($urandom_range(0, 1));
         r.step = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         r.satm = satm_r;
         r.load = ($urandom_range(0, 9) == 0);
         r.lv   = 4'($urandom_range(0, 15));
         r.mw   = ($urandom_range(0, 11) == 0);
         r.mv   = 5'($urandom_range(0, 31));
         r.e_out = 0; r.e_mod = 0; r.e_tc = 1'b0; r.e_sat = 1'b0; r.e_err = 1'b0;
         drive(r);
         model_edge(r);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d_out", c), int'(cnt_out), m_out);
         chk($sformatf("rnd%0d_mod", c), int'(mod_q), m_mod);
         chk($sformatf("rnd%0d_tc", c), int'(tc), m_tc);
         chk($sformatf("rnd%0d_sat", c), int'(sat), m_sat);
         chk($sformatf("rnd%0d_err", c), int'(err), m_err);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
